// File: rtl/lsu.sv
// lsu: load/store unit sequencing one execute-stage operation through a
// request/grant/rvalid memory port and a one-cycle writeback pulse.
module lsu #(
    parameter int WD_SIZE = 32,
    parameter int OPCODE_SIZE = 7,
    parameter int FUNCT3_SIZE = 3,
    parameter logic [OPCODE_SIZE-1:0] OPCODE_LD = 7'b0000011,
    parameter logic [OPCODE_SIZE-1:0] OPCODE_ST = 7'b0100011
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [OPCODE_SIZE-1:0] opcode_i,
    input  logic [FUNCT3_SIZE-1:0] funct3_i,
    input  logic [WD_SIZE-1:0]     addr_i,
    input  logic [WD_SIZE-1:0]     st_data_i,
    input  logic [4:0]             rd_i,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [WD_SIZE-1:0]     mem_addr_o,
    output logic [3:0]             mem_be_o,
    output logic [WD_SIZE-1:0]     mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [WD_SIZE-1:0]     mem_rdata_i,
    output logic                   wb_valid_o,
    output logic                   wb_we_o,
    output logic [4:0]             wb_rd_o,
    output logic [WD_SIZE-1:0]     wb_data_o,
    output logic                   err_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [FUNCT3_SIZE-1:0] f3_q;
    logic [WD_SIZE-1:0] addr_q, sd_q, wb_data_q, sh, ld_data;
    logic [4:0] rd_q;
    logic st_q, we_q, err_q;
    logic is_ld, is_st, is_mem, illegal, misaligned, bad, accept, sx, in_req, resp;
    logic [1:0] off, sz;
    logic [3:0] be;
    logic [WD_SIZE-1:0] wdata;
    always_comb begin
        is_ld = opcode_i == OPCODE_LD;
        is_st = opcode_i == OPCODE_ST;
        is_mem = is_ld || is_st;
        illegal = is_ld ? funct3_i[1] && (funct3_i[0] || funct3_i[2]) : funct3_i[2] || &funct3_i[1:0];
        misaligned = (funct3_i[1:0] == 2'b01 && addr_i[0]) || (funct3_i[1:0] == 2'b10 && |addr_i[1:0]);
        bad = is_mem && (illegal || misaligned);
        accept = valid_i && state == IDLE;
    end
    always_ff @(posedge clk or posedge reset_n)
        if (reset_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (valid_i) state_nx = (is_mem && !bad) ? REQ : RESP;
            REQ:  if (mem_gnt_i) state_nx = st_q ? RESP : WAIT;
            WAIT: if (mem_rvalid_i) state_nx = RESP;
            RESP: state_nx = IDLE;
        endcase
    end
    // Lane steering and load extraction use the captured low address bits.
    always_comb begin
        off = addr_q[1:0];
        sz = f3_q[1:0];
        sx = !f3_q[2];
        be = sz == 2'b00 ? 4'b0001 << off : sz == 2'b01 ? 4'b0011 << off : 4'b1111;
        wdata = sz == 2'b00 ? {4{sd_q[7:0]}} : sz == 2'b01 ? {2{sd_q[15:0]}} : sd_q;
        sh = mem_rdata_i >> {off, 3'b000};
        ld_data = sz == 2'b00 ? {{(WD_SIZE-8){sx && sh[7]}}, sh[7:0]} :
                  sz == 2'b01 ? {{(WD_SIZE-16){sx && sh[15]}}, sh[15:0]} : mem_rdata_i;
        in_req = state == REQ;
        resp = state == RESP;
        ready_o = state == IDLE;
        mem_req_o = in_req;
        mem_we_o = in_req && st_q;
        mem_addr_o = in_req ? {addr_q[WD_SIZE-1:2], 2'b00} : '0;
        mem_be_o = in_req ? be : 4'b0000;
        mem_wdata_o = in_req ? wdata : '0;
        wb_valid_o = resp;
        wb_we_o = resp && we_q;
        err_o = resp && err_q;
        wb_rd_o = resp ? rd_q : 5'd0;
        wb_data_o = resp ? wb_data_q : '0;
    end
    always_ff @(posedge clk or posedge reset_n)
        if (reset_n) begin
            f3_q <= '0;
            addr_q <= '0;
            sd_q <= '0;
            rd_q <= '0;
            st_q <= 1'b0;
            we_q <= 1'b0;
            err_q <= 1'b0;
            wb_data_q <= '0;
        end else if (accept) begin
            f3_q <= funct3_i;
            addr_q <= addr_i;
            sd_q <= st_data_i;
            rd_q <= rd_i;
            st_q <= is_st;
            we_q <= !is_mem;
            err_q <= bad;
            wb_data_q <= is_mem ? '0 : addr_i;
        end else if (state == WAIT && mem_rvalid_i) begin
            wb_data_q <= ld_data;
            we_q <= 1'b1;
        end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed vectors for lsu; expectations are queued by the stimulus
// and consumed by independent memory-side and writeback-side monitors.
module tb_lsu;
    localparam logic [6:0] LD = 7'h03, ST = 7'h23, ALU = 7'h33;
    logic clk = 0, reset_n = 0, valid_i = 0;
    logic [6:0] opcode_i = 0;
    logic [2:0] funct3_i = 0;
    logic [31:0] addr_i = 0, st_data_i = 0, mem_rdata_i = 0;
    logic [4:0] rd_i = 0;
    logic ready_o, mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, wb_valid_o, wb_we_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, wb_data_o;
    logic [3:0] mem_be_o;
    logic [4:0] wb_rd_o;
    int gnt_delay = 0, req_cnt = 0, cyc = 0, total = 0, passed = 0;
    bit auto_rv = 1, auto_q = 0, force_rv = 0;

    typedef struct { logic [4:0] rd; logic we; logic err; logic [31:0] data; int at; } wb_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int cycles; } mr_t;
    wb_t wq[$];
    mr_t mq[$];

    lsu dut (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .addr_i(addr_i), .st_data_i(st_data_i),
        .rd_i(rd_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_o),
        .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) req_cnt <= (mem_req_o && !mem_gnt_i) ? req_cnt + 1 : 0;
    always @(posedge clk) auto_q <= auto_rv && mem_req_o && mem_gnt_i && !mem_we_o;
    assign mem_gnt_i = mem_req_o && req_cnt >= gnt_delay;
    assign mem_rvalid_i = auto_q || force_rv;

    function automatic void chk(string n, logic [71:0] act, logic [71:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    endfunction

    initial begin
        mr_t m;
        int mcnt;
        mcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                if (mq.size() == 0) chk("mem_unexpected_req", 1, 0);
                else begin
                    m = mq[0];
                    mcnt++;
                    chk("mem_we", mem_we_o, m.we);
                    chk("mem_addr", mem_addr_o, m.addr);
                    chk("mem_be", mem_be_o, m.be);
                    if (m.we) chk("mem_wdata", mem_wdata_o, m.wdata);
                    if (mem_gnt_i) begin
                        chk("mem_req_cycles", mcnt, m.cycles);
                        void'(mq.pop_front());
                        mcnt = 0;
                    end
                end
            end else chk("mem_idle_zero", {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, 0);
        end
    end

    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (wb_valid_o) begin
                if (wq.size() == 0) chk("wb_unexpected", 1, 0);
                else begin
                    e = wq.pop_front();
                    chk("wb_rd", wb_rd_o, e.rd);
                    chk("wb_we", wb_we_o, e.we);
                    chk("wb_err", err_o, e.err);
                    if (e.we) chk("wb_data", wb_data_o, e.data);
                    chk("wb_latency_cycle", cyc, e.at);
                end
            end else chk("err_without_valid", err_o, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish by %0t", $time);
        $fatal(1);
    end

    task automatic mexp(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input int cycles);
        mq.push_back('{we, a, be, wd, cycles});
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input int lat, input bit exp_wb, input logic we, input logic err,
                         input logic [31:0] data);
        int n = 0;
        opcode_i = op; funct3_i = f3; addr_i = a; st_data_i = sd; rd_i = rd; valid_i = 1;
        while (!ready_o && n < 50) begin @(posedge clk); #1; n++; end
        chk("accept_ready", ready_o, 1);
        @(posedge clk); #1;
        valid_i = 0;
        if (exp_wb) wq.push_back('{rd, we, err, data, cyc + lat - 1});
    endtask

    task automatic drain();
        int n = 0;
        while ((wq.size() != 0 || mq.size() != 0 || !ready_o) && n < 100) begin @(posedge clk); #1; n++; end
        chk("drain_complete", wq.size() == 0 && mq.size() == 0 && ready_o, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, ready_o, 1);
        chk({tag, "_ctrl"}, {mem_req_o, mem_we_o, wb_valid_o, wb_we_o, err_o}, 0);
        chk({tag, "_mem"}, {mem_addr_o, mem_be_o, mem_wdata_o}, 0);
        chk({tag, "_wb"}, {wb_rd_o, wb_data_o}, 0);
    endtask

    initial begin
        #1 reset_n = 1;
        #1 check_reset("reset_initial");
        @(posedge clk); #1 reset_n = 0;
        @(posedge clk); #1;
        issue(ALU, 3'b000, 32'h1234, 0, 5'd5, 1, 1, 1, 0, 32'h1234); drain();
        mexp(1, 32'h100, 4'b1000, 32'hA5A5A5A5, 1);
        issue(ST, 3'b000, 32'h103, 32'hA5, 5'd7, 2, 1, 0, 0, 0); drain();
        mexp(1, 32'h100, 4'b1100, 32'hBEEFBEEF, 1);
        issue(ST, 3'b001, 32'h102, 32'h1234BEEF, 5'd7, 2, 1, 0, 0, 0); drain();
        mexp(1, 32'h104, 4'b1111, 32'hDEADBEEF, 1);
        issue(ST, 3'b010, 32'h104, 32'hDEADBEEF, 5'd8, 2, 1, 0, 0, 0); drain();
        gnt_delay = 3; mem_rdata_i = 32'h80011234;
        mexp(0, 32'h200, 4'b1100, 0, 4);
        issue(LD, 3'b001, 32'h202, 0, 5'd9, 6, 1, 1, 0, 32'hFFFF8001); drain();
        mexp(0, 32'h200, 4'b1100, 0, 4);
        issue(LD, 3'b101, 32'h202, 0, 5'd9, 6, 1, 1, 0, 32'h00008001); drain();
        gnt_delay = 0; mem_rdata_i = 32'h00008000;
        mexp(0, 32'h100, 4'b0010, 0, 1);
        issue(LD, 3'b000, 32'h101, 0, 5'd10, 3, 1, 1, 0, 32'hFFFFFF80); drain();
        mexp(0, 32'h100, 4'b0010, 0, 1);
        issue(LD, 3'b100, 32'h101, 0, 5'd10, 3, 1, 1, 0, 32'h00000080); drain();
        mem_rdata_i = 32'h12345678;
        mexp(0, 32'h400, 4'b1111, 0, 1);
        issue(LD, 3'b010, 32'h400, 0, 5'd11, 3, 1, 1, 0, 32'h12345678); drain();
        issue(LD, 3'b010, 32'h301, 0, 5'd3, 1, 1, 0, 1, 0); drain();
        issue(LD, 3'b011, 32'h300, 0, 5'd3, 1, 1, 0, 1, 0); drain();
        issue(ST, 3'b100, 32'h300, 32'h55, 5'd4, 1, 1, 0, 1, 0); drain();
        issue(ST, 3'b001, 32'h101, 32'h55, 5'd4, 1, 1, 0, 1, 0); drain();
        issue(LD, 3'b001, 32'h203, 0, 5'd4, 1, 1, 0, 1, 0); drain();
        auto_rv = 0;
        mexp(0, 32'h500, 4'b1111, 0, 1);
        issue(LD, 3'b010, 32'h500, 0, 5'd13, 0, 0, 0, 0, 0);
        @(posedge clk); #3 reset_n = 1;
        #1 check_reset("reset_in_wait");
        chk("reset_mem_queue_empty", mq.size(), 0);
        @(posedge clk); #1 reset_n = 0; mem_rdata_i = 32'hFFFFFFFF; force_rv = 1;
        @(posedge clk); #1 force_rv = 0;
        chk("ready_after_late_rvalid", ready_o, 1);
        @(posedge clk); #1;
        auto_rv = 1; mem_rdata_i = 32'hCAFEF00D;
        mexp(0, 32'h504, 4'b1111, 0, 1);
        issue(LD, 3'b010, 32'h504, 0, 5'd12, 3, 1, 1, 0, 32'hCAFEF00D); drain();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have parameter WD_SIZE, default 32: data and address width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-high reset (asserted = 1).
REQ-004 The block SHALL have port valid_i, input, 1 bit: the execute stage presents an operation.
REQ-005 The block SHALL have port ready_o, output, 1 bit: the LSU can accept an operation this cycle.
REQ-006 The block SHALL have port opcode_i, input, OPCODE_SIZE bits: instruction opcode; OPCODE_LD and OPCODE_ST are memory operations.
REQ-007 The block SHALL have port funct3_i, input, FUNCT3_SIZE bits: access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 The block SHALL have port addr_i, input, WD_SIZE bits: execute result; the effective address for memory operations, the writeback value otherwise.
REQ-009 The block SHALL have port st_data_i, input, WD_SIZE bits: rs2 data for stores.
REQ-010 The block SHALL have port rd_i, input, 5 bits: destination register index.
REQ-011 The block SHALL have port mem_req_o, output, 1 bit: memory request.
REQ-012 The block SHALL have port mem_we_o, output, 1 bit: write request (1) or read request (0).
REQ-013 The block SHALL have port mem_addr_o, output, WD_SIZE bits: word-aligned address, with [1:0] = 00.
REQ-014 The block SHALL have ports mem_be_o (output, 4 bits: byte enables) and mem_wdata_o (output, WD_SIZE bits: lane-replicated store data).
REQ-015 The block SHALL have ports mem_gnt_i (input, 1 bit: request accepted), mem_rvalid_i (input, 1 bit: read data valid) and mem_rdata_i (input, WD_SIZE bits: read data).
REQ-016 The block SHALL have ports wb_valid_o (output, 1 bit), wb_we_o (output, 1 bit: register write enable), wb_rd_o (output, 5 bits), wb_data_o (output, WD_SIZE bits) and err_o (output, 1 bit: misaligned access or illegal funct3).

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and RESP.
REQ-018 ready_o SHALL be 1 only in IDLE; an operation SHALL be accepted at a rising edge with valid_i=1 and ready_o=1, capturing opcode, funct3, addr, st_data and rd.
REQ-019 An accepted non-memory opcode SHALL go IDLE->RESP with wb_data_o=addr and wb_we_o=1.
REQ-020 An accepted memory operation SHALL go IDLE->RESP with err_o=1 and wb_we_o=0, with no memory request, when funct3 is illegal or the address is misaligned.
REQ-021 Illegal funct3 SHALL mean 011, 110 or 111 for loads, and any value other than 000, 001 or 010 for stores.
REQ-022 Misaligned SHALL mean a halfword access with addr[0]=1, or a word access with addr[1:0]≠00.
REQ-023 A legal memory operation SHALL go IDLE->REQ.
REQ-024 In REQ, mem_req_o=1 and mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o SHALL be held stable until mem_gnt_i=1 is sampled.
REQ-025 On that grant, a store SHALL go to RESP with wb_we_o=0, and a load SHALL go to WAIT.
REQ-026 In WAIT, mem_req_o=0; the block SHALL wait indefinitely for mem_rvalid_i=1, then register the extracted data and go to RESP.
REQ-027 mem_rvalid_i SHALL be ignored outside WAIT, and mem_gnt_i SHALL be ignored outside REQ.
REQ-028 RESP SHALL last exactly one cycle with wb_valid_o=1, wb_rd_o=captured rd and err_o as determined, then go to IDLE; err_o SHALL be 0 whenever wb_valid_o=0.
REQ-029 With off=addr[1:0], stores SHALL drive: SB be=0001<<off and wdata={4{st_data[7:0]}}; SH be=0011<<off and wdata={2{st_data[15:0]}}; SW be=1111 and wdata=st_data.
REQ-030 Loads SHALL drive mem_be_o as for stores of the same size.
REQ-031 Load data SHALL be extracted as: LB sign-extends byte lane off; LBU zero-extends it; LH/LHU sign-/zero-extend the halfword at off; LW passes the word unchanged.
REQ-032 Latency SHALL be counted from the accept edge N to the wb_valid_o cycle: non-memory or error, 1 cycle; store with immediate grant, 2 cycles; load with immediate grant and rvalid one cycle later, 3 cycles.
REQ-033 mem_addr_o, mem_be_o, mem_wdata_o and mem_we_o SHALL be 0 outside REQ.

Reset
REQ-034 On reset_n=1, the FSM SHALL enter IDLE asynchronously, and mem_req_o, wb_valid_o, err_o, wb_we_o, mem_we_o and all data, address and byte-enable outputs SHALL go to 0 immediately; ready_o SHALL be 1.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction with no writeback, and a late mem_rvalid_i after reset SHALL be ignored.

Verification
REQ-036 The bench SHALL check: ADD result, addr=0x1234, rd=5 -> next cycle wb_valid=1, we=1, rd=5, data=0x00001234, no mem_req.
REQ-037 The bench SHALL check: SB addr=0x103, st_data=0xA5, gnt in the first REQ cycle -> mem_addr=0x100, be=1000, wdata=0xA5A5A5A5, wb_valid 2 cycles after accept with we=0.
REQ-038 The bench SHALL check: LH addr=0x202, rdata=0x8001xxxx, gnt held off 3 cycles -> mem_req stable for 4 cycles, then wb_data=0xFFFF8001; with LHU, wb_data=0x00008001.
REQ-039 The bench SHALL check: LW addr=0x301 -> no mem_req, wb_valid=1 with err_o=1 and we=0 one cycle after accept; funct3=011 on a load -> same response.
REQ-040 The bench SHALL check: reset asserted while in WAIT, followed by rvalid -> outputs 0 and ready_o=1 immediately, no wb_valid pulse, and the next LW completes normally.
